tdm_lane_demux: RTL

//  Receive end of the lane multiplexer: rebuilds LANES parallel words from one TDM word stream.
//  The transmitter selects one lane per beat through its 2:1 mux tree, starting at lane 0.

---
 rtl/tdm_pkg.sv | 20 ++
 rtl/tdm_slot_ctr.sv | 37 +++
 rtl/tdm_lane_demux.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM lane multiplexer/demultiplexer pair.
package tdm_pkg;

    localparam int LANES_DEF = 4;
    localparam int WIDTH_DEF = 8;

    typedef enum logic {
        ST_HUNT = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    // Extracts lane k from a flattened frame bus of the default geometry.
    function automatic logic [WIDTH_DEF-1:0] lane_of(
        input logic [LANES_DEF*WIDTH_DEF-1:0] bus,
        input int                             k
    );
        return bus[k*WIDTH_DEF +: WIDTH_DEF];
    endfunction

endpackage

// File: rtl/tdm_slot_ctr.sv
// Slot index counter: tracks which lane the next valid beat belongs to.
module tdm_slot_ctr
    import tdm_pkg::*;
#(
    parameter  int LANES = LANES_DEF,
    localparam int SLW   = $clog2(LANES)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic           i_load1,
    input  logic           i_clear,
    input  logic           i_inc,
    output logic [SLW-1:0] o_sl,
    output logic           o_last
);

    localparam logic [SLW-1:0] LAST_SLOT = SLW'(LANES - 1);

    logic [SLW-1:0] r_sl;

    // Clear beats load-1 beats increment; increment wraps after the last lane.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sl <= '0;
        end else if (i_clear) begin
            r_sl <= '0;
        end else if (i_load1) begin
            r_sl <= SLW'(1);
        end else if (i_inc) begin
            r_sl <= (r_sl == LAST_SLOT) ? '0 : r_sl + 1'b1;
        end
    end

    assign o_sl   = r_sl;
    assign o_last = (r_sl == LAST_SLOT);

endmodule

// File: rtl/tdm_lane_demux.sv
// TDM receive demultiplexer: rebuilds LANES parallel words from a framed beat stream.
module tdm_lane_demux
    import tdm_pkg::*;
#(
    parameter  int LANES = LANES_DEF,
    parameter  int WIDTH = WIDTH_DEF,
    localparam int SLW   = $clog2(LANES)
) (
    input  logic                   CK,
    input  logic                   RN,
    input  logic [WIDTH-1:0]       D,
    input  logic                   DV,
    input  logic                   FS,
    input  logic                   CLR_ERR,
    output logic [LANES*WIDTH-1:0] Q,
    output logic                   QV,
    output logic [SLW-1:0]         SL,
    output logic                   LOCK,
    output logic                   ERR
);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [WIDTH-1:0]       r_shadow [LANES-1];
    logic [LANES*WIDTH-1:0] r_q;
    logic [LANES*WIDTH-1:0] w_frame;
    logic                   r_qv;
    logic                   r_err;

    logic [SLW-1:0]         w_sl;
    logic                   w_last;
    logic                   w_load1;
    logic                   w_clear;
    logic                   w_inc;
    logic                   w_wr_en;
    logic [SLW-1:0]         w_wr_idx;
    logic                   w_publish;
    logic                   w_err_set;

    tdm_slot_ctr #(
        .LANES (LANES)
    ) u_slot_ctr (
        .i_clk   (CK),
        .i_rst_n (RN),
        .i_load1 (w_load1),
        .i_clear (w_clear),
        .i_inc   (w_inc),
        .o_sl    (w_sl),
        .o_last  (w_last)
    );

    // State register.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_state <= ST_HUNT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Framing decisions for the current beat: slot control, shadow write, publish, error.
    always_comb begin
        w_state_nxt = r_state;
        w_load1     = 1'b0;
        w_clear     = 1'b0;
        w_inc       = 1'b0;
        w_wr_en     = 1'b0;
        w_wr_idx    = w_sl;
        w_publish   = 1'b0;
        w_err_set   = 1'b0;
        if (DV) begin
            case (r_state)
                ST_HUNT: begin
                    if (FS) begin
                        w_load1     = 1'b1;
                        w_wr_en     = 1'b1;
                        w_wr_idx    = '0;
                        w_state_nxt = ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    if (FS && (w_sl != '0)) begin
                        w_err_set = 1'b1;
                        w_load1   = 1'b1;
                        w_wr_en   = 1'b1;
                        w_wr_idx  = '0;
                    end else if (!FS && (w_sl == '0)) begin
                        w_err_set   = 1'b1;
                        w_clear     = 1'b1;
                        w_state_nxt = ST_HUNT;
                    end else if (w_last) begin
                        w_publish = 1'b1;
                        w_inc     = 1'b1;
                    end else begin
                        w_wr_en = 1'b1;
                        w_inc   = 1'b1;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    // Completed frame: stored lanes plus the final lane taken straight from the bus.
    always_comb begin
        w_frame = '0;
        for (int k = 0; k < LANES - 1; k++) begin
            w_frame[k*WIDTH +: WIDTH] = r_shadow[k];
        end
        w_frame[(LANES-1)*WIDTH +: WIDTH] = D;
    end

    // Shadow buffer collects all but the last lane of the frame in progress.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            for (int k = 0; k < LANES - 1; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            for (int k = 0; k < LANES - 1; k++) begin
                if (w_wr_en && (w_wr_idx == SLW'(k))) begin
                    r_shadow[k] <= D;
                end
            end
        end
    end

    // Publish the frame atomically and pulse QV for one cycle.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_q  <= '0;
            r_qv <= 1'b0;
        end else begin
            r_qv <= w_publish;
            if (w_publish) begin
                r_q <= w_frame;
            end
        end
    end

    // Sticky framing error; a new error takes priority over a clear.
    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (CLR_ERR) begin
            r_err <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign QV   = r_qv;
    assign SL   = w_sl;
    assign LOCK = (r_state == ST_LOCK);
    assign ERR  = r_err;

endmodule
